ring_fifo: RTL

Parametrised single-clock FIFO built on a power-of-two ring of registers. It accepts a read and a write in the same cycle, reports its fill level and an almost-full threshold, and registers its read data with a one-cycle valid strobe. It sits between sample producers (oscillator and envelope stages) and consumers running at uneven rates in the synth datapath.

---
 rtl/ring_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ring_fifo.sv
// ring_fifo: single-clock FIFO on a power-of-two register ring with registered read data.
// Define RING_FIFO_ERR_EN to add the sticky overflow/underflow ports.
module ring_fifo #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned N           = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
`ifdef RING_FIFO_ERR_EN
    output logic [N:0]       count,
    output logic             overflow,
    output logic             underflow
`else
    output logic [N:0]       count
`endif
);

    localparam int unsigned DEPTH = 2 ** N;
    localparam int unsigned PW    = N + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;

    logic [PW-1:0]    count_c;
    logic             empty_c;
    logic             full_c;
    logic             almost_full_c;
    logic             rd_accept_c;
    logic             wr_accept_c;

    // Status flags depend only on the registered pointers.
    always_comb begin
        count_c       = head_q - tail_q;
        empty_c       = (count_c == '0);
        full_c        = (count_c == PW'(DEPTH));
        almost_full_c = (count_c >= PW'(AFULL_LEVEL));
    end

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_accept_c = rd_en & ~empty_c;
        wr_accept_c = wr_en & (~full_c | rd_accept_c);
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (wr_accept_c) begin
            head_d = head_q + PW'(1);
        end
        if (rd_accept_c) begin
            tail_d       = tail_q + PW'(1);
            data_out_d   = mem_q[tail_q[N-1:0]];
            data_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept_c) begin
            mem_q[head_q[N-1:0]] <= data_in;
        end
    end

`ifdef RING_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (wr_en & ~wr_accept_c);
        underflow_d = underflow_q | (rd_en & empty_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign empty       = empty_c;
    assign full        = full_c;
    assign almost_full = almost_full_c;
    assign count       = count_c;

endmodule
